mult_seq: RTL and testbench

Sequential 32×32 radix-2 shift-add multiplier for the MIPS core's MULT/MULTU instructions. It is the companion to the iterative divider and drives the HI/LO register path with the same start/busy/over handshake. It converts signed operands to magnitudes, runs one add-shift step per cycle, and applies the sign correction on the output. The pipeline stalls on `busy` and writes HI/LO when `over` is high.

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/mult_seq_if.sv | 23 ++
 rtl/mult_seq_abs_conv.sv | 17 +
 rtl/mult_seq.sv | 105 ++++++++++
 tb/tb_mult_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// Shared constants and state type for the sequential multiply/divide unit.
// The iterative divider uses the same width constants.
package mult_seq_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic int md_cnt_last(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/over handshake bundle between the pipeline and the HI/LO multiplier.
interface mult_seq_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             is_signed;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             over;

  modport master (
    output multiplicand, multiplier, is_signed, start,
    input  hi, lo, busy, over
  );

  modport slave (
    input  multiplicand, multiplier, is_signed, start,
    output hi, lo, busy, over
  );
endinterface

// File: rtl/mult_seq_abs_conv.sv
// Signed-to-magnitude conversion. The most negative value maps to itself,
// which is still correct when read as an unsigned magnitude.
module abs_conv #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_is_signed,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign o_sign = i_is_signed & i_val[WIDTH-1];
  assign o_mag  = o_sign ? (~i_val + ONE) : i_val;

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier for MULT/MULTU feeding HI/LO.
//   state   | meaning
//   IDLE    | no result held, busy=0 over=0
//   RUN     | one add-shift step per edge, busy=1
//   DONE    | product held on hi/lo, over=1
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clock,
  input  logic     reset,
  mult_seq_if.slave bus
);

  localparam int                CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(md_cnt_last(WIDTH));
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] P_ONE   = (2*WIDTH)'(1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_mag_a;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic               w_last;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_prod;

  abs_conv #(.WIDTH(WIDTH)) u_abs_a (
    .i_val       (bus.multiplicand),
    .i_is_signed (bus.is_signed),
    .o_mag       (w_mag_a),
    .o_sign      (w_sign_a)
  );

  abs_conv #(.WIDTH(WIDTH)) u_abs_b (
    .i_val       (bus.multiplier),
    .i_is_signed (bus.is_signed),
    .o_mag       (w_mag_b),
    .o_sign      (w_sign_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_last = (r_cnt == CNT_LAST);

  // start wins over everything, including an iteration in flight
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_addend = r_q[0] ? {1'b0, r_mag_a} : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_mag_a <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.start) begin
      r_acc   <= '0;
      r_q     <= w_mag_b;
      r_mag_a <= w_mag_a;
      r_neg   <= w_sign_a ^ w_sign_b;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      {r_acc, r_q} <= {w_sum, r_q} >> 1;
      r_cnt        <= r_cnt + CNT_ONE;
    end
  end

  assign w_raw  = {r_acc[WIDTH-1:0], r_q};
  assign w_prod = r_neg ? (~w_raw + P_ONE) : w_raw;

  assign bus.hi   = w_prod[2*WIDTH-1:WIDTH];
  assign bus.lo   = w_prod[WIDTH-1:0];
  assign bus.busy = (r_state == ST_RUN);
  assign bus.over = (r_state == ST_DONE);

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq: products, latency, restart and reset abort.
module tb_mult_seq;

  logic clock;
  logic reset;
  int   n_run;
  int   n_fail;

  mult_seq_if #(.WIDTH(32)) bus ();

  mult_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Caller sits just after a falling edge; start is seen on the next rising edge.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    bus.start        = 1'b1;
    @(negedge clock);
    bus.start        = 1'b0;
    bus.multiplicand = 32'hDEAD_BEEF;
    bus.multiplier   = 32'h1234_5678;
  endtask

  task automatic wait_over(output int lat, output int nbusy);
    lat   = 0;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.over && lat < 40) begin
      @(negedge clock);
      lat++;
      if (bus.busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.is_signed = 1'b0;
    #12;
    n_run++;
    if ({bus.busy, bus.over, bus.hi, bus.lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b over=%b hi=%h lo=%h, want all 0", bus.busy, bus.over, bus.hi, bus.lo);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_run++;
    if (bus.busy !== 1'b0 || bus.over !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b over=%b, want 0 0", bus.busy, bus.over);
    end
  endtask

  task automatic test_signed_small;
    int lat, nb;
    drive_start(32'd7, 32'd6, 1'b1);
    n_run++;
    if (bus.busy !== 1'b1 || bus.over !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_start: busy=%b over=%b, want 1 0", bus.busy, bus.over);
    end
    wait_over(lat, nb);
    n_run++;
    if (lat !== 32) begin
      n_fail++;
      $display("FAIL latency_7x6: got %0d cycles, want 32", lat);
    end
    n_run++;
    if (nb !== 32) begin
      n_fail++;
      $display("FAIL busy_width_7x6: busy high %0d cycles, want 32", nb);
    end
    n_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h2A) begin
      n_fail++;
      $display("FAIL prod_7x6: hi=%h lo=%h, want 00000000 0000002a", bus.hi, bus.lo);
    end
    repeat (3) @(negedge clock);
    n_run++;
    if (bus.over !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== 32'h2A) begin
      n_fail++;
      $display("FAIL done_hold: over=%b busy=%b lo=%h, want 1 0 0000002a", bus.over, bus.busy, bus.lo);
    end
  endtask

  task automatic test_signed_neg;
    int lat, nb;
    drive_start(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_over(lat, nb);
    n_run++;
    if (lat !== 32 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      n_fail++;
      $display("FAIL prod_m3x5: lat=%0d hi=%h lo=%h, want 32 ffffffff fffffff1", lat, bus.hi, bus.lo);
    end
  endtask

  task automatic test_all_ones;
    int lat, nb;
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_over(lat, nb);
    n_run++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL prod_u_ffxff: hi=%h lo=%h, want fffffffe 00000001", bus.hi, bus.lo);
    end
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_over(lat, nb);
    n_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h1) begin
      n_fail++;
      $display("FAIL prod_s_m1xm1: hi=%h lo=%h, want 00000000 00000001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_min_int;
    int lat, nb;
    drive_start(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_over(lat, nb);
    n_run++;
    if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
      n_fail++;
      $display("FAIL prod_min_sq: hi=%h lo=%h, want 40000000 00000000", bus.hi, bus.lo);
    end
    drive_start(32'h8000_0000, 32'h1, 1'b1);
    wait_over(lat, nb);
    n_run++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL prod_min_x1: hi=%h lo=%h, want ffffffff 80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    // over is high now; restart on the very next edge
    drive_start(32'd100, 32'd1000, 1'b0);
    n_run++;
    if (bus.over !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_over_drop: over=%b busy=%b, want 0 1", bus.over, bus.busy);
    end
    wait_over(lat, nb);
    n_run++;
    if (lat !== 32 || bus.hi !== 32'h0 || bus.lo !== 32'd100000) begin
      n_fail++;
      $display("FAIL b2b_prod: lat=%0d hi=%h lo=%h, want 32 00000000 000186a0", lat, bus.hi, bus.lo);
    end
  endtask

  task automatic test_restart;
    int lat, nb;
    logic seen_over;
    seen_over = 1'b0;
    drive_start(32'd3, 32'd3, 1'b0);
    repeat (9) begin
      @(negedge clock);
      if (bus.over) seen_over = 1'b1;
    end
    drive_start(32'd2, 32'd9, 1'b0);
    if (bus.over) seen_over = 1'b1;
    wait_over(lat, nb);
    n_run++;
    if (seen_over !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_no_old_over: over seen=%b, want 0", seen_over);
    end
    n_run++;
    if (lat !== 32) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d cycles, want 32", lat);
    end
    n_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h12) begin
      n_fail++;
      $display("FAIL restart_prod: hi=%h lo=%h, want 00000000 00000012", bus.hi, bus.lo);
    end
  endtask

  task automatic test_mid_reset;
    drive_start(32'hFFFF_FFFD, 32'd5, 1'b1);
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_run++;
    if ({bus.busy, bus.over, bus.hi, bus.lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b over=%b hi=%h lo=%h, want all 0", bus.busy, bus.over, bus.hi, bus.lo);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    n_run++;
    if ({bus.busy, bus.over, bus.hi, bus.lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL post_reset_hold: busy=%b over=%b hi=%h lo=%h, want all 0", bus.busy, bus.over, bus.hi, bus.lo);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_signed_small();
    test_signed_neg();
    test_all_ones();
    test_min_int();
    test_back_to_back();
    test_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
